// File: rtl/ifetch_pq.sv
// ifetch_pq: instruction-fetch unit with a decoupling prefetch queue.
//
// Fetch keeps at most one request in flight to a synchronous ROM. Returned
// words are pushed into a circular queue together with their byte PC. Decode
// drains the queue over a valid/ready handshake. A redirect flushes the
// queue, cancels the in-flight request and restarts fetch at the new target.
//
// Ports:
//   clock          single clock; all state updates on the rising edge
//   reset          asynchronous, active-low; clears all state
//   redirect_valid take a branch/jump/exception target this cycle
//   redirect_pc    target byte address (bits [1:0] forced to 0)
//   rom_addr       ROM word address (pc[ADDR_W+1:2]); data returns next cycle
//   rom_data       ROM read data for the previous cycle's rom_addr
//   out_valid      queue head is valid
//   out_ready      decode accepts the head
//   out_inst       head instruction
//   out_pc         head byte PC
//   out_pc_plus_4  out_pc + 4, modulo 2^32
//   count          current queue occupancy
module ifetch_pq #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [31:0]                  rom_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_inst,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_pc_plus_4,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [31:0]      pc;
  logic             pend_valid;
  logic [31:0]      pend_pc;

  logic [31:0]      q_inst [DEPTH];
  logic [31:0]      q_pc   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic [CNT_W:0]   inflight;
  logic             issue;
  logic             push;
  logic             pop;

  // Queued entries plus the outstanding request must never exceed DEPTH,
  // so a returning word always has a free slot to land in.
  always_comb begin
    inflight = {1'b0, count} + {{CNT_W{1'b0}}, pend_valid};
    issue    = !redirect_valid && (inflight < (CNT_W+1)'(DEPTH));
    pop      = out_valid && out_ready && !redirect_valid;
    push     = pend_valid && !redirect_valid;
  end

  assign rom_addr      = pc[ADDR_W+1:2];
  assign out_valid     = (count != '0);
  assign out_inst      = q_inst[rd_ptr];
  assign out_pc        = q_pc[rd_ptr];
  assign out_pc_plus_4 = out_pc + 32'd4;

  // Fetch PC and the single in-flight ROM request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC & ~32'h3;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (redirect_valid) begin
      pc         <= redirect_pc & ~32'h3;
      pend_valid <= 1'b0;
    end else if (issue) begin
      pend_valid <= 1'b1;
      pend_pc    <= pc;
      pc         <= pc + 32'd4;
    end else begin
      pend_valid <= 1'b0;
    end
  end

  // Circular prefetch queue; pointers wrap naturally since DEPTH is 2^PTR_W.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      q_inst <= '{default: '0};
      q_pc   <= '{default: '0};
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_inst[wr_ptr] <= rom_data;
        q_pc[wr_ptr]   <= pend_pc;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_pq.sv
// tb_ifetch_pq: directed and randomized bench for ifetch_pq against a
// queue-based reference model of the fetch stream.
module tb_ifetch_pq;

  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clock = 1'b0;
  logic              reset;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc_plus_4;
  logic [2:0]        count;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  ifetch_pq #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_pc_plus_4 (out_pc_plus_4),
    .count         (count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  // Synchronous ROM: one-cycle read latency.
  always_ff @(posedge clock) rom_data <= rom_word(rom_addr);

  // Reference model: next fetch PC, outstanding request, queue of entries.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  ent_t        m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC & ~32'h3;
    m_pend    = 1'b0;
    m_pend_pc = '0;
    m_q.delete();
  endtask

  task automatic model_edge();
    int unsigned sz;
    bit          pend0;
    ent_t        e;
    if (!reset) begin
      model_reset();
      return;
    end
    sz    = m_q.size();
    pend0 = m_pend;
    if (redirect_valid) begin
      m_q.delete();
      m_pend = 1'b0;
      m_pc   = {redirect_pc[31:2], 2'b00};
    end else begin
      if (sz != 0 && out_ready) e = m_q.pop_front();
      if (pend0) begin
        e.inst = rom_word(m_pend_pc[ADDR_W+1:2]);
        e.pc   = m_pend_pc;
        m_q.push_back(e);
      end
      if (sz + pend0 < DEPTH) begin
        m_pend    = 1'b1;
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end else begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    chk("count", 32'(count), m_q.size());
    chk("count_le_depth", 32'(count <= 3'(DEPTH)), 32'd1);
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("rom_addr", 32'(rom_addr), 32'(m_pc[ADDR_W+1:2]));
    if (m_q.size() != 0) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_inst", out_inst, m_q[0].inst);
      chk("out_pc_plus_4", out_pc_plus_4, m_q[0].pc + 32'd4);
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then
  // compare shortly after the edge. Inputs change only after this returns.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    model_reset();

    // Reset state
    repeat (2) step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'(RESET_PC[ADDR_W+1:2]));

    // Start-up stream
    reset = 1'b1;
    step();
    chk("start_e1_valid", 32'(out_valid), 32'd0);
    step();
    chk("start_e2_valid", 32'(out_valid), 32'd1);
    chk("start_pc0", out_pc, 32'h0);
    chk("start_inst0", out_inst, 32'h1000_0000);
    step();
    chk("start_pc4", out_pc, 32'h4);
    chk("start_pc4_plus4", out_pc_plus_4, 32'h8);
    repeat (5) step();
    chk("stream_pc24", out_pc, 32'd24);

    // Stall saturates and freezes fetch
    out_ready = 1'b0;
    repeat (10) step();
    chk("stall_count", 32'(count), 32'd4);
    chk("stall_rom_addr", 32'(rom_addr), 32'd10);
    chk("stall_head", out_pc, 32'd24);
    out_ready = 1'b1;
    repeat (4) step();
    chk("release_no_gap", out_pc, 32'd40);

    // Redirect with three queued entries
    out_ready = 1'b0;
    step();
    chk("pre_redirect_count", 32'(count), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    chk("redir_flush_count", 32'(count), 32'd0);
    chk("redir_rom_addr", 32'(rom_addr), 32'h40);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    step();
    chk("redir_t1_valid", 32'(out_valid), 32'd0);
    step();
    chk("redir_t2_valid", 32'(out_valid), 32'd1);
    chk("redir_t2_pc", out_pc, 32'h100);
    repeat (2) step();

    // Redirect on a handshake cycle, then back-to-back redirects
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    step();
    chk("dbl_redir_gap", 32'(out_valid), 32'd0);
    step();
    chk("dbl_redir_pc", out_pc, 32'h80);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    repeat (2) step();
    chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    chk("wrap_inst0", out_inst, 32'h1000_3FFE);
    step();
    chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    chk("wrap_pc1_plus4", out_pc_plus_4, 32'h0);
    step();
    chk("wrap_pc2", out_pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0;

    // Asynchronous reset mid-stream with a full queue
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    out_ready      = 1'b0;
    step();
    redirect_valid = 1'b0;
    repeat (6) step();
    chk("pre_reset_full", 32'(count), 32'd4);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_rom_addr", 32'(rom_addr), 32'(RESET_PC[ADDR_W+1:2]));
    step();
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (2) step();
    chk("restart_pc", out_pc, RESET_PC & ~32'h3);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
